// File: rtl/gcd_requester.sv
// gcd_requester: initiator for the GCD start/valid protocol; issues NUM_REQ operand pairs,
// captures results/latency, recovers hangs by timeout. Define GCD_REQ_CHECK_EN for the reference checker.
module gcd_requester #(
    parameter int W       = 6,
    parameter int NUM_REQ = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [15:0]  seed,
    input  logic         fix_en,
    input  logic [W-1:0] fix_a,
    input  logic [W-1:0] fix_b,
    output logic         gcd_start,
    output logic         gcd_reset,
    output logic [W-1:0] gcd_ain,
    output logic [W-1:0] gcd_bin,
    input  logic [W-1:0] gcd_out,
    input  logic         gcd_valid,
    output logic         busy,
    output logic         done,
    output logic [7:0]   req_count,
    output logic [7:0]   to_count,
    output logic [7:0]   err_count,
    output logic [W-1:0] last_result,
    output logic [7:0]   last_lat
);
    localparam int LW = $clog2(TIMEOUT + 1);
    localparam int NW = $clog2(NUM_REQ + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_CHECK, S_NEXT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d, lfsr_src;
    logic [W-1:0]   ain_q, ain_d, bin_q, bin_d, res_q, res_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic [NW-1:0]  n_q, n_d;
    logic [7:0]     req_q, req_d, to_q, to_d, llat_q, llat_d;
    logic           start, grst, issue;
`ifdef GCD_REQ_CHECK_EN
    logic [7:0]     err_q, err_d;
    logic [W-1:0]   ra_q, ra_d, rb_q, rb_d;
`endif

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Zero operands would hang the responder, so they become 1.
    function automatic logic [W-1:0] nz(input logic [W-1:0] x);
        return (x == '0) ? W'(1) : x;
    endfunction

    function automatic logic [7:0] inc8(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        ain_d    = ain_q;
        bin_d    = bin_q;
        lat_d    = lat_q;
        n_d      = n_q;
        req_d    = req_q;
        to_d     = to_q;
        res_d    = res_q;
        llat_d   = llat_q;
        start    = 1'b0;
        grst     = 1'b0;
        issue    = 1'b0;
        lfsr_src = lfsr_q;
`ifdef GCD_REQ_CHECK_EN
        err_d = err_q;
        ra_d  = ra_q;
        rb_d  = rb_q;
        // Subtract/swap Euclid; rb reaching zero means ra holds the gcd.
        if (rb_q != '0) begin
            if (ra_q < rb_q) begin
                ra_d = rb_q;
                rb_d = ra_q;
            end else begin
                ra_d = ra_q - rb_q;
            end
        end
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d  = S_ISSUE;
                    req_d    = '0;
                    to_d     = '0;
                    n_d      = '0;
                    lfsr_src = (seed == 16'h0) ? 16'hACE1 : seed;
                    issue    = 1'b1;
`ifdef GCD_REQ_CHECK_EN
                    err_d = '0;
`endif
                end
            end
            S_ISSUE: begin
                start   = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (gcd_valid) begin
                    res_d   = gcd_out;
                    llat_d  = (32'(lat_q) > 32'd255) ? 8'hFF : 8'(lat_q);
                    state_d = S_CHECK;
                end else if (lat_q == LW'(TIMEOUT)) begin
                    grst    = 1'b1;
                    to_d    = inc8(to_q);
                    state_d = S_NEXT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_CHECK: begin
`ifdef GCD_REQ_CHECK_EN
                if (rb_q == '0) begin
                    if (res_q != ra_q) err_d = inc8(err_q);
                    state_d = S_NEXT;
                end
`else
                state_d = S_NEXT;
`endif
            end
            S_NEXT: begin
                req_d = inc8(req_q);
                n_d   = n_q + 1'b1;
                if (n_q + 1'b1 == NW'(NUM_REQ)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    issue   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Operands are registered on ISSUE entry so they are valid while start is high.
        if (issue) begin
            ain_d  = nz(fix_en ? fix_a : lfsr_src[W-1:0]);
            bin_d  = nz(fix_en ? fix_b : lfsr_src[2*W-1:W]);
            lfsr_d = lfsr_step(lfsr_src);
`ifdef GCD_REQ_CHECK_EN
            ra_d = ain_d;
            rb_d = bin_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= 16'hACE1;
            ain_q   <= '0;
            bin_q   <= '0;
            lat_q   <= '0;
            n_q     <= '0;
            req_q   <= '0;
            to_q    <= '0;
            res_q   <= '0;
            llat_q  <= '0;
`ifdef GCD_REQ_CHECK_EN
            err_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            lat_q   <= lat_d;
            n_q     <= n_d;
            req_q   <= req_d;
            to_q    <= to_d;
            res_q   <= res_d;
            llat_q  <= llat_d;
`ifdef GCD_REQ_CHECK_EN
            err_q   <= err_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
`endif
        end
    end

    // Strobes fall in the reset cycle itself, not one cycle later.
    assign gcd_start   = start & ~reset;
    assign gcd_reset   = grst & ~reset;
    assign gcd_ain     = ain_q;
    assign gcd_bin     = bin_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign req_count   = req_q;
    assign to_count    = to_q;
    assign last_result = res_q;
    assign last_lat    = llat_q;
`ifdef GCD_REQ_CHECK_EN
    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif

endmodule
